// File: rtl/step_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : step_input_ctrl
// Brief   : Synchronises, debounces and arms the board push-buttons and jump
//           switches, producing a one-cycle step enable and select levels.
// Revision: 1.0  initial release
// ============================================================================
module step_input_ctrl #(
  parameter int DB_COUNT = 50000,
  parameter int CNT_W    = 16,
  parameter int STEP_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btnRaw,
  input  logic              btnSelectRaw,
  input  logic              btnWRselectRaw,
  input  logic              btnMuxExRaw,
  input  logic [3:0]        jmpAddrRaw,
  output logic              stepPulse,
  output logic              selectOut,
  output logic              wrSelectOut,
  output logic              muxExOut,
  output logic [3:0]        jmpAddr,
  output logic [STEP_W-1:0] stepCount
);

  localparam int c_NUM_BTN  = 4;
  localparam int c_BTN_STEP = 0;
  localparam int c_BTN_SEL  = 1;
  localparam int c_BTN_WR   = 2;
  localparam int c_BTN_MUX  = 3;
  localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DB_COUNT - 1);

  logic [c_NUM_BTN-1:0] w_btn_raw;
  logic [c_NUM_BTN-1:0] btn_meta_q;
  logic [c_NUM_BTN-1:0] btn_sync_q;
  logic [3:0]           jmp_meta_q;
  logic [3:0]           jmp_sync_q;
  logic [1:0]           prime_q;
  logic [c_NUM_BTN-1:0] w_press;
  logic                 w_wr_level;

  assign w_btn_raw = {btnMuxExRaw, btnWRselectRaw, btnSelectRaw, btnRaw};

  // prime_q[1] marks the sync chain as holding real samples rather than reset zeros
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      jmp_meta_q <= '0;
      jmp_sync_q <= '0;
      prime_q    <= '0;
    end else begin
      btn_meta_q <= w_btn_raw;
      btn_sync_q <= btn_meta_q;
      jmp_meta_q <= jmpAddrRaw;
      jmp_sync_q <= jmp_meta_q;
      prime_q    <= {prime_q[0], 1'b1};
    end
  end

  for (genvar b = 0; b < c_NUM_BTN; b++) begin : g_btn
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic             armed_q;
    logic             armed_d;
    logic             armed_prev_q;

    // Arming needs a genuinely released button, so one held through reset stays inert
    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (btn_sync_q[b] != level_q) begin
        if (cnt_q == c_DB_LAST) begin
          level_d = ~level_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      armed_d = armed_q | (prime_q[1] & ~level_q & ~btn_sync_q[b]);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q        <= '0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
        armed_q      <= 1'b0;
        armed_prev_q <= 1'b0;
      end else begin
        cnt_q        <= cnt_d;
        level_q      <= level_d;
        level_prev_q <= level_q;
        armed_q      <= armed_d;
        armed_prev_q <= armed_q;
      end
    end

    // armed_prev_q is the armed state in the cycle before the level rose
    assign w_press[b] = level_q & ~level_prev_q & armed_prev_q;

    if (b == c_BTN_WR) begin : g_wr_level
      assign w_wr_level = level_q & armed_q;
    end
  end

  logic              step_pulse_q;
  logic              step_pulse_d;
  logic              select_q;
  logic              select_d;
  logic              wr_select_q;
  logic              wr_select_d;
  logic              mux_ex_q;
  logic              mux_ex_d;
  logic [3:0]        jmp_addr_q;
  logic [3:0]        jmp_addr_d;
  logic [STEP_W-1:0] step_count_q;
  logic [STEP_W-1:0] step_count_d;

  always_comb begin
    step_pulse_d = w_press[c_BTN_STEP];
    select_d     = select_q ^ w_press[c_BTN_SEL];
    mux_ex_d     = mux_ex_q ^ w_press[c_BTN_MUX];
    wr_select_d  = w_wr_level;
    jmp_addr_d   = jmp_addr_q;
    step_count_d = step_count_q;
    if (w_press[c_BTN_STEP]) begin
      jmp_addr_d   = jmp_sync_q;
      step_count_d = step_count_q + STEP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_pulse_q <= 1'b0;
      select_q     <= 1'b0;
      wr_select_q  <= 1'b0;
      mux_ex_q     <= 1'b0;
      jmp_addr_q   <= '0;
      step_count_q <= '0;
    end else begin
      step_pulse_q <= step_pulse_d;
      select_q     <= select_d;
      wr_select_q  <= wr_select_d;
      mux_ex_q     <= mux_ex_d;
      jmp_addr_q   <= jmp_addr_d;
      step_count_q <= step_count_d;
    end
  end

  assign stepPulse   = step_pulse_q;
  assign selectOut   = select_q;
  assign wrSelectOut = wr_select_q;
  assign muxExOut    = mux_ex_q;
  assign jmpAddr     = jmp_addr_q;
  assign stepCount   = step_count_q;

endmodule
`default_nettype wire

// File: tb/tb_step_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_step_input_ctrl
// Brief   : Scoreboard bench for step_input_ctrl (DB_COUNT=4, STEP_W=4).
// Revision: 1.0  initial release
// ============================================================================
module tb_step_input_ctrl;

  localparam int c_DB     = 4;
  localparam int c_STEP_W = 4;
  // raw change sampled at the next edge, 2 sync edges, 4 debounce edges, 1 output edge
  localparam int c_LAT    = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              btnRaw = 1'b0;
  logic              btnSelectRaw = 1'b0;
  logic              btnWRselectRaw = 1'b0;
  logic              btnMuxExRaw = 1'b0;
  logic [3:0]        jmpAddrRaw = 4'h0;
  logic              stepPulse;
  logic              selectOut;
  logic              wrSelectOut;
  logic              muxExOut;
  logic [3:0]        jmpAddr;
  logic [c_STEP_W-1:0] stepCount;

  step_input_ctrl #(
    .DB_COUNT(c_DB),
    .CNT_W   (16),
    .STEP_W  (c_STEP_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btnRaw        (btnRaw),
    .btnSelectRaw  (btnSelectRaw),
    .btnWRselectRaw(btnWRselectRaw),
    .btnMuxExRaw   (btnMuxExRaw),
    .jmpAddrRaw    (jmpAddrRaw),
    .stepPulse     (stepPulse),
    .selectOut     (selectOut),
    .wrSelectOut   (wrSelectOut),
    .muxExOut      (muxExOut),
    .jmpAddr       (jmpAddr),
    .stepCount     (stepCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic       step;
    logic       sel;
    logic       wr;
    logic       mux;
    logic [3:0] jmp;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model of the output state
  logic       m_sel = 1'b0;
  logic       m_wr  = 1'b0;
  logic       m_mux = 1'b0;
  logic [3:0] m_jmp = 4'h0;
  logic [3:0] m_cnt = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: any pulse or level change on the outputs is one scoreboard event
  exp_t e;
  logic p_sel = 1'b0;
  logic p_wr  = 1'b0;
  logic p_mux = 1'b0;
  always @(negedge clk) begin
    if (!reset && (stepPulse || selectOut !== p_sel || wrSelectOut !== p_wr || muxExOut !== p_mux)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: cycle %0d step=%b sel=%b wr=%b mux=%b cnt=%0d",
                 cyc, stepPulse, selectOut, wrSelectOut, muxExOut, stepCount);
      end else begin
        e = sb.pop_front();
        check("event_cycle", 32'(cyc), 32'(e.at));
        check("event_outputs",
              {20'h0, stepPulse, selectOut, wrSelectOut, muxExOut, jmpAddr, stepCount},
              {20'h0, e.step, e.sel, e.wr, e.mux, e.jmp, e.cnt});
      end
    end
    p_sel = selectOut;
    p_wr  = wrSelectOut;
    p_mux = muxExOut;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int at, input logic st);
    exp_t x;
    x.at = at; x.step = st; x.sel = m_sel; x.wr = m_wr;
    x.mux = m_mux; x.jmp = m_jmp; x.cnt = m_cnt;
    sb.push_back(x);
  endtask

  task automatic press(input logic st, input logic se, input logic mx, input int hold);
    btnRaw = st; btnSelectRaw = se; btnMuxExRaw = mx;
    if (st) begin
      m_cnt = m_cnt + 4'd1;
      m_jmp = jmpAddrRaw;
    end
    if (se) m_sel = ~m_sel;
    if (mx) m_mux = ~m_mux;
    push_exp(cyc + c_LAT, st);
    tick(hold);
    btnRaw = 1'b0; btnSelectRaw = 1'b0; btnMuxExRaw = 1'b0;
    tick(12);
  endtask

  task automatic do_reset();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    reset = 1'b1;
    #1;
    check("reset_outputs",
          {22'h0, stepPulse, selectOut, wrSelectOut, muxExOut, jmpAddr, stepCount}, 32'h0);
    m_sel = 1'b0; m_wr = 1'b0; m_mux = 1'b0; m_jmp = 4'h0; m_cnt = 4'h0;
    tick(3);
    reset = 1'b0;
    tick(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    tick(2);
    do_reset();

    // clean press held 20 cycles
    press(1'b1, 1'b0, 1'b0, 20);
    check("count_after_first_step", 32'(stepCount), 32'd1);

    // bounce 1,0,1,0 then held
    do_reset();
    btnRaw = 1'b1; tick(1);
    btnRaw = 1'b0; tick(1);
    btnRaw = 1'b1; tick(1);
    btnRaw = 1'b0; tick(1);
    press(1'b1, 1'b0, 1'b0, 15);
    check("count_after_bounce", 32'(stepCount), 32'd1);

    // jump address latched only on steps
    jmpAddrRaw = 4'hA; tick(3);
    press(1'b1, 1'b0, 1'b0, 10);
    jmpAddrRaw = 4'h3; tick(10);
    check("jmp_held_between_steps", 32'(jmpAddr), 32'hA);
    press(1'b1, 1'b0, 1'b0, 10);
    check("jmp_after_second_step", 32'(jmpAddr), 32'h3);

    // select toggles three times
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0, 8);
    check("select_after_three", 32'(selectOut), 32'd1);

    // WR-select follows the debounced level
    btnWRselectRaw = 1'b1; m_wr = 1'b1; push_exp(cyc + c_LAT, 1'b0);
    tick(15);
    check("wr_while_held", 32'(wrSelectOut), 32'd1);
    btnWRselectRaw = 1'b0; m_wr = 1'b0; push_exp(cyc + c_LAT, 1'b0);
    tick(12);
    check("wr_after_release", 32'(wrSelectOut), 32'd0);

    // simultaneous step and MuxEx
    press(1'b1, 1'b0, 1'b1, 10);
    check("mux_after_simultaneous", 32'(muxExOut), 32'd1);

    // button held through reset never acts until re-pressed
    btnRaw = 1'b1; tick(2);
    do_reset();
    tick(20);
    check("held_through_reset_count", 32'(stepCount), 32'd0);
    btnRaw = 1'b0; tick(12);
    press(1'b1, 1'b0, 1'b0, 10);
    check("count_after_repress", 32'(stepCount), 32'd1);

    // reset mid-debounce aborts the press
    do_reset();
    btnRaw = 1'b1; tick(4);
    reset = 1'b1; btnRaw = 1'b0; tick(2);
    reset = 1'b0; tick(20);
    check("mid_debounce_reset_count", 32'(stepCount), 32'd0);

    // 16 presses wrap the 4-bit counter
    do_reset();
    for (int i = 0; i < 16; i++) press(1'b1, 1'b0, 1'b0, 6);
    check("count_wrap", 32'(stepCount), 32'd0);

    tick(5);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
